hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined MIPS core. It sits beside decode and tracks in-flight register writes in a scoreboard spanning the DEPTH stages after decode. It issues stall, bubble and flush controls to fetch/decode/execute, and a registered forwarding select per source operand for the execute-stage operand muxes. It supports any pipeline depth and any load latency.

## Interface
- ADDR_W, 5, register address width
- DEPTH, 3, tracked stages after decode (1 = EX … DEPTH = WB); ≥2
- LOAD_LAT, 2, distance at which load data becomes forwardable; 1 ≤ LOAD_LAT ≤ DEPTH
- FWD_W, $clog2(DEPTH+1), derived width of forwarding selects
- i_clk  in  1  core clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_id_valid  in  1  decode holds a valid instruction
- i_id_rs, i_id_rt  in  ADDR_W  source register addresses
- i_id_use_rs, i_id_use_rt  in  1  operand actually read
- i_id_wr_en  in  1  instruction writes a register
- i_id_wr_addr  in  ADDR_W  destination register
- i_id_is_load  in  1  instruction is a load
- i_ex_branch_taken  in  1  branch in EX resolved taken this cycle
- o_stall  out  1  hold PC and IF/ID register
- o_bubble  out  1  insert NOP into ID/EX register
- o_flush  out  1  squash IF/ID contents
- o_ex_fwd_rs, o_ex_fwd_rt  out  FWD_W  registered select for instruction in EX: 0 = register file, d = result of producer d instructions older
- o_inflight  out  $clog2(DEPTH+1)  valid scoreboard entries
- o_stall_cnt, o_flush_cnt  out  32  event counters (see Configuration)

## Operation
- Scoreboard: slots 1..DEPTH, each {valid, addr, is_load}; slot 1 = instruction in EX.
- Every cycle slot[k+1] ← slot[k]; slot DEPTH retires. Slot 1 ← decode entry if issued, else invalid.
- Issue = i_id_valid & !o_stall & !o_flush. Entry valid only if i_id_wr_en and i_id_wr_addr ≠ 0.
- Match for rs: use_rs, rs ≠ 0, valid slot with addr == rs. Take the smallest k (youngest producer). Same rule for rt.
- Load-use hazard: matched youngest slot has is_load and k < LOAD_LAT. An older load behind a younger ALU match is not a hazard.
- o_stall = o_bubble = i_id_valid & hazard(rs|rt) & !i_ex_branch_taken. Combinational.
- o_flush = i_ex_branch_taken. Combinational. Flush has priority over stall. The decode instruction is squashed and slot 1 gets a bubble.
- o_ex_fwd_*: registered on issue with k of the youngest match, else 0. Cleared to 0 on stall or flush cycles.
- Forwarding distance equals the registered k. The EX mux maps d=1 → EX/MEM result, d=2 → MEM/WB result, d=DEPTH → WB write data.

## Timing
- Reset: all slots invalid; o_ex_fwd_* = 0, o_inflight = 0, counters = 0. The combinational outputs follow from empty state: o_stall = o_bubble = 0, o_flush = i_ex_branch_taken.
- Async reset mid-stall clears the scoreboard immediately. Decode re-evaluates from empty next cycle.
- Stall lasts exactly LOAD_LAT − k cycles for a load at distance k. The bubble advances the load each cycle.
- o_ex_fwd_* is valid in the same cycle the consumer occupies EX (one cycle after decode issue).
- A producer in slot DEPTH still forwards (d = DEPTH). Once retired, the register file holds the value (write-before-read).
- A simultaneous branch flush and load-use hazard produces flush=1, stall=0, bubble=0, and slot 1 invalid.

## Configuration
- HAZ_PERF_CNT_EN defined: o_stall_cnt increments on each cycle with o_stall=1. o_flush_cnt increments on each cycle with o_flush=1. Both saturate at 32'hFFFF_FFFF and reset to 0.
- HAZ_PERF_CNT_EN not defined: no counter registers; both ports tied to 0.

## Test plan
- add $3 then add $5,$3,$1 back-to-back → no stall; o_ex_fwd_rs=1 in consumer EX cycle.
- lw $4 then add $6,$4,$4 (LOAD_LAT=2) → o_stall=o_bubble=1 for one cycle, then o_ex_fwd_rs=o_ex_fwd_rt=2.
- add $0,… then read $0 → no stall, o_ex_fwd_rs=0, o_inflight unchanged by that instruction.
- addi $7 at distance 2 and sub $7 at distance 1, consumer reads $7 → o_ex_fwd_rs=1; lw $7 at d=2 behind ALU $7 at d=1 → no stall.
- Load-use hazard with i_ex_branch_taken=1 same cycle → o_flush=1, o_stall=0, next-cycle slot 1 invalid, o_ex_fwd_*=0; o_flush_cnt+1 with HAZ_PERF_CNT_EN.
- Assert i_rst during a stall with 3 slots valid → o_inflight=0 and o_ex_fwd_*=0 immediately; o_stall=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight register writes for DEPTH stages after decode.
// Optional event counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned FWD_W    = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [ADDR_W-1:0] i_id_rs,
    input  logic [ADDR_W-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic              i_id_wr_en,
    input  logic [ADDR_W-1:0] i_id_wr_addr,
    input  logic              i_id_is_load,
    input  logic              i_ex_branch_taken,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_flush,
    output logic [FWD_W-1:0]  o_ex_fwd_rs,
    output logic [FWD_W-1:0]  o_ex_fwd_rt,
    output logic [FWD_W-1:0]  o_inflight,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
);

    localparam int unsigned CNT_W = 32;

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [FWD_W-1:0]             fwd_rs_q, fwd_rs_d;
    logic [FWD_W-1:0]             fwd_rt_q, fwd_rt_d;
    logic [FWD_W-1:0]             inflight_q, inflight_d;

    logic [FWD_W-1:0] rs_dist, rt_dist;
    logic             rs_load, rt_load;
    logic             hazard, issue;

    // Youngest-producer search; descending loop leaves the smallest matching distance.
    always_comb begin
        rs_dist = '0;
        rs_load = 1'b0;
        rt_dist = '0;
        rt_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_id_use_rs && (i_id_rs != '0) && valid_q[k-1] && (addr_q[k-1] == i_id_rs)) begin
                rs_dist = FWD_W'(k);
                rs_load = load_q[k-1];
            end
            if (i_id_use_rt && (i_id_rt != '0) && valid_q[k-1] && (addr_q[k-1] == i_id_rt)) begin
                rt_dist = FWD_W'(k);
                rt_load = load_q[k-1];
            end
        end
    end

    assign hazard   = (rs_load && (rs_dist < FWD_W'(LOAD_LAT)))
                   || (rt_load && (rt_dist < FWD_W'(LOAD_LAT)));
    assign o_flush  = i_ex_branch_taken;
    assign o_stall  = i_id_valid && hazard && !i_ex_branch_taken;
    assign o_bubble = o_stall;
    assign issue    = i_id_valid && !o_stall && !o_flush;

    always_comb begin
        valid_d    = {valid_q[DEPTH-2:0], issue && i_id_wr_en && (i_id_wr_addr != '0)};
        load_d     = {load_q[DEPTH-2:0], i_id_is_load};
        addr_d     = {addr_q[DEPTH-2:0], i_id_wr_addr};
        fwd_rs_d   = issue ? rs_dist : '0;
        fwd_rt_d   = issue ? rt_dist : '0;
        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight_d = inflight_d + FWD_W'(valid_d[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= '0;
            load_q     <= '0;
            addr_q     <= '0;
            fwd_rs_q   <= '0;
            fwd_rt_q   <= '0;
            inflight_q <= '0;
        end else begin
            valid_q    <= valid_d;
            load_q     <= load_d;
            addr_q     <= addr_d;
            fwd_rs_q   <= fwd_rs_d;
            fwd_rt_q   <= fwd_rt_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_ex_fwd_rs = fwd_rs_q;
    assign o_ex_fwd_rt = fwd_rt_q;
    assign o_inflight  = inflight_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (o_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = CNT_W'(0);
    assign o_flush_cnt = CNT_W'(0);
`endif

endmodule
